router_reg: RTL

//  Datapath register stage of the 1x3 router; consumes the state flags of the router FSM
//  and produces the byte stream written into the selected output FIFO.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_if.sv | 29 ++
 rtl/router_parity_acc.sv | 36 +++
 rtl/router_reg.sv | 82 ++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared widths, the never-accepted header address and the router FSM state encoding.
// Imported by the register stage, its parity sub-block, the interface users and the bench.
package router_pkg;
  localparam int         DATA_WIDTH   = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef logic [DATA_WIDTH-1:0] byte_t;

  typedef enum logic [2:0] {
    ST_DECODE_ADDRESS,
    ST_LOAD_FIRST_DATA,
    ST_LOAD_DATA,
    ST_LOAD_PARITY,
    ST_FIFO_FULL_STATE,
    ST_LOAD_AFTER_FULL,
    ST_WAIT_TILL_EMPTY,
    ST_CHECK_PARITY_ERROR
  } fsm_state_t;
endpackage

// File: rtl/router_if.sv
// Byte stream, FIFO full flag, FSM state flags and status returns between the router FSM side
// (master) and the datapath register stage (slave).
interface router_if;
  router_pkg::byte_t din;
  logic              pkt_valid;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  router_pkg::byte_t dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;

  modport master (
    output din, pkt_valid, fifo_full, rst_int_reg, detect_add,
           lfd_state, ld_state, laf_state, full_state,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  din, pkt_valid, fifo_full, rst_int_reg, detect_add,
           lfd_state, ld_state, laf_state, full_state,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes; compares against the captured parity byte
// one clock after parity_done rises and holds err until the next packet starts.
module router_parity_acc
  import router_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  xor_en,
  input  byte_t xor_dat,
  input  byte_t pkt_parity,
  input  logic  parity_done,
  output logic  err
);
  byte_t int_parity;
  logic  parity_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_parity    <= '0;
      parity_done_q <= 1'b0;
      err           <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      if (clr)
        int_parity <= '0;
      else if (xor_en)
        int_parity <= int_parity ^ xor_dat;
      // Compare only on the rising edge of parity_done so err is a per-packet verdict.
      if (clr)
        err <= 1'b0;
      else if (parity_done && !parity_done_q)
        err <= (int_parity != pkt_parity);
    end
  end
endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header hold, one-byte full buffer, parity capture and check.
// All outputs registered, one clk after the qualifying FSM flags; stalls by holding dout.
module router_reg
  import router_pkg::*;
(
  input logic     clk,
  input logic     rst,
  router_if.slave bus
);
  byte_t hdr_byte;
  byte_t full_byte;
  byte_t pkt_parity;
  byte_t dout_q;
  logic  parity_done_q;
  logic  low_pkt_valid_q;
  logic  pc_ld;
  logic  pc_laf;
  logic  xor_en;
  byte_t xor_dat;
  logic  err_w;

  assign pc_ld  = bus.ld_state & ~bus.fifo_full & ~bus.pkt_valid;
  assign pc_laf = bus.laf_state & low_pkt_valid_q & ~parity_done_q;

  // The trailing parity byte (pkt_valid low) never enters the running XOR.
  assign xor_en  = bus.lfd_state | (bus.ld_state & bus.pkt_valid & ~bus.full_state);
  assign xor_dat = bus.lfd_state ? hdr_byte : bus.din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_byte        <= '0;
      full_byte       <= '0;
      pkt_parity      <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_valid && (bus.din[1:0] != ADDR_INVALID))
        hdr_byte <= bus.din;
      if (bus.ld_state && bus.fifo_full)
        full_byte <= bus.din;

      if (bus.lfd_state)
        dout_q <= hdr_byte;
      else if (bus.ld_state && !bus.fifo_full)
        dout_q <= bus.din;
      else if (bus.laf_state)
        dout_q <= full_byte;

      if (pc_ld)
        pkt_parity <= bus.din;
      else if (pc_laf)
        pkt_parity <= full_byte;

      if (bus.detect_add)
        parity_done_q <= 1'b0;
      else if (pc_ld || pc_laf)
        parity_done_q <= 1'b1;

      if (bus.rst_int_reg)
        low_pkt_valid_q <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid)
        low_pkt_valid_q <= 1'b1;
    end
  end

  router_parity_acc u_parity (
    .clk         (clk),
    .rst         (rst),
    .clr         (bus.detect_add),
    .xor_en      (xor_en),
    .xor_dat     (xor_dat),
    .pkt_parity  (pkt_parity),
    .parity_done (parity_done_q),
    .err         (err_w)
  );

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_w;
endmodule
